// File: rtl/pe8_context_loader.sv
// -----------------------------------------------------------------------------
// pe8_context_loader
//
// Upstream feeder for PE8. It accepts context words from the shared
// configuration bus and keeps only the beats tagged with PE_ID. Kept words are
// written, in arrival order, into the PE context cache one cycle after they are
// accepted. After the final word has loaded, the global go request starts the
// PE. The PE then runs until the global halt request stops it.
//
// Ports
//   CLK, RST_N    clock (rising edge) and asynchronous active-low reset
//   cfg_valid     config beat valid
//   cfg_ready     always 1; the shared bus never stalls
//   cfg_pe_id     destination PE of the beat
//   cfg_data      context word (WIDTH+1 bits)
//   cfg_last      final word for the tagged PE
//   go, halt      global run / stop requests
//   ctx_wr        cache write strobe, one cycle per stored word
//   ctx_addr      cache slot being written
//   ctx_data      word being written
//   start         PE run level, high exactly while in RUN
//   busy          high while in LOAD or ARMED
//   words_loaded  words written in the current load, saturates at DEPTH
//   err_overflow  sticky: a matching word was dropped
// -----------------------------------------------------------------------------
module pe8_context_loader #(
    parameter int WIDTH  = 120,
    parameter int PE_ID  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_pe_id,
    input  logic [WIDTH:0]    cfg_data,
    input  logic              cfg_last,
    input  logic              go,
    input  logic              halt,
    output logic              ctx_wr,
    output logic [ADDR_W-1:0] ctx_addr,
    output logic [WIDTH:0]    ctx_data,
    output logic              start,
    output logic              busy,
    output logic [ADDR_W:0]   words_loaded,
    output logic              err_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W + 1)'(1);

    state_t              state_r;
    state_t              state_nxt_s;
    logic                ctx_wr_r;
    logic                ctx_wr_nxt_s;
    logic [ADDR_W-1:0]   ctx_addr_r;
    logic [ADDR_W-1:0]   ctx_addr_nxt_s;
    logic [WIDTH:0]      ctx_data_r;
    logic [WIDTH:0]      ctx_data_nxt_s;
    logic [ADDR_W:0]     words_r;
    logic [ADDR_W:0]     words_nxt_s;
    logic                err_r;
    logic                err_nxt_s;
    logic                start_r;
    logic                start_nxt_s;
    logic                busy_r;
    logic                busy_nxt_s;
    logic                beat_s;
    logic                match_s;

    // The shared bus is never back-pressured, so every valid cycle is a beat.
    assign cfg_ready = 1'b1;
    assign beat_s    = cfg_valid & cfg_ready;
    assign match_s   = beat_s & (cfg_pe_id == 4'(PE_ID));

    assign ctx_wr       = ctx_wr_r;
    assign ctx_addr     = ctx_addr_r;
    assign ctx_data     = ctx_data_r;
    assign start        = start_r;
    assign busy         = busy_r;
    assign words_loaded = words_r;
    assign err_overflow = err_r;

    // Next-state, cache write and status computation.
    always_comb begin
        state_nxt_s    = state_r;
        ctx_wr_nxt_s   = 1'b0;
        ctx_addr_nxt_s = ctx_addr_r;
        ctx_data_nxt_s = ctx_data_r;
        words_nxt_s    = words_r;
        err_nxt_s      = err_r;

        case (state_r)
            ST_IDLE: begin
                if (match_s) begin
                    ctx_wr_nxt_s   = 1'b1;
                    ctx_addr_nxt_s = '0;
                    ctx_data_nxt_s = cfg_data;
                    words_nxt_s    = ONE_W;
                    err_nxt_s      = 1'b0;
                    if (cfg_last) begin
                        state_nxt_s = ST_ARMED;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (match_s) begin
                    // A full cache drops the word rather than wrapping.
                    if (words_r < DEPTH_W) begin
                        ctx_wr_nxt_s   = 1'b1;
                        ctx_addr_nxt_s = words_r[ADDR_W-1:0];
                        ctx_data_nxt_s = cfg_data;
                        words_nxt_s    = words_r + ONE_W;
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                    if (cfg_last) begin
                        state_nxt_s = ST_ARMED;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_ARMED: begin
                // halt is not looked at here, so go wins when both are high.
                if (go) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
                if (match_s) begin
                    err_nxt_s = 1'b1;
                end else begin
                    err_nxt_s = err_r;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_nxt_s = ST_IDLE;
                    words_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_RUN;
                end
                if (match_s) begin
                    err_nxt_s = 1'b1;
                end else begin
                    err_nxt_s = err_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        start_nxt_s = (state_nxt_s == ST_RUN);
        busy_nxt_s  = (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_ARMED);
    end

    // State and registered outputs; reset aborts any load or run at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= ST_IDLE;
            ctx_wr_r   <= 1'b0;
            ctx_addr_r <= '0;
            ctx_data_r <= '0;
            words_r    <= '0;
            err_r      <= 1'b0;
            start_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ctx_wr_r   <= ctx_wr_nxt_s;
            ctx_addr_r <= ctx_addr_nxt_s;
            ctx_data_r <= ctx_data_nxt_s;
            words_r    <= words_nxt_s;
            err_r      <= err_nxt_s;
            start_r    <= start_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_pe8_context_loader.sv
// -----------------------------------------------------------------------------
// tb_pe8_context_loader
//
// Directed bench for pe8_context_loader. Inputs change 1 time unit after the
// rising edge, and outputs are checked at the same point. Expected values are
// worked out by hand from the load sequence.
// -----------------------------------------------------------------------------
module tb_pe8_context_loader;

    logic         CLK;
    logic         RST_N;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [3:0]   cfg_pe_id;
    logic [120:0] cfg_data;
    logic         cfg_last;
    logic         go;
    logic         halt;
    logic         ctx_wr;
    logic [3:0]   ctx_addr;
    logic [120:0] ctx_data;
    logic         start;
    logic         busy;
    logic [4:0]   words_loaded;
    logic         err_overflow;

    int n_cmp;
    int n_bad;

    pe8_context_loader dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_pe_id    (cfg_pe_id),
        .cfg_data     (cfg_data),
        .cfg_last     (cfg_last),
        .go           (go),
        .halt         (halt),
        .ctx_wr       (ctx_wr),
        .ctx_addr     (ctx_addr),
        .ctx_data     (ctx_data),
        .start        (start),
        .busy         (busy),
        .words_loaded (words_loaded),
        .err_overflow (err_overflow)
    );

    // Free-running clock, period 10.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [120:0] mk_data(input int k);
        logic [31:0] hi;
        hi = 32'hA5C3_0000 + 32'(k);
        return {hi, 89'(k * 7 + 3)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One bus beat; checks the cache write it should (or should not) cause.
    task automatic beat(input string tag, input logic [3:0] id, input int k, input logic last,
                        input logic exp_wr, input logic [3:0] exp_addr);
        cfg_valid = 1'b1;
        cfg_pe_id = id;
        cfg_data  = mk_data(k);
        cfg_last  = last;
        check_val({tag, "_ready"}, 128'(cfg_ready), 128'(1'b1));
        tick();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        check_val({tag, "_wr"}, 128'(ctx_wr), 128'(exp_wr));
        if (exp_wr) begin
            check_val({tag, "_addr"}, 128'(ctx_addr), 128'(exp_addr));
            check_val({tag, "_data"}, 128'(ctx_data), 128'(mk_data(k)));
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        RST_N     = 1'b0;
        cfg_valid = 1'b1;
        cfg_pe_id = 4'd8;
        cfg_data  = mk_data(99);
        cfg_last  = 1'b0;
        go        = 1'b0;
        halt      = 1'b0;

        // T1: reset held with a matching beat on the bus.
        tick();
        tick();
        check_val("rst_wr",    128'(ctx_wr),       128'(1'b0));
        check_val("rst_addr",  128'(ctx_addr),     128'(4'd0));
        check_val("rst_data",  128'(ctx_data),     128'(121'd0));
        check_val("rst_start", 128'(start),        128'(1'b0));
        check_val("rst_busy",  128'(busy),         128'(1'b0));
        check_val("rst_words", 128'(words_loaded), 128'(5'd0));
        check_val("rst_err",   128'(err_overflow), 128'(1'b0));
        cfg_valid = 1'b0;
        RST_N     = 1'b1;
        tick();
        check_val("idle_wr", 128'(ctx_wr), 128'(1'b0));

        // T2: load three words, then go.
        beat("t2_a", 4'd8, 1, 1'b0, 1'b1, 4'd0);
        check_val("t2_busy_load", 128'(busy), 128'(1'b1));
        beat("t2_b", 4'd8, 2, 1'b0, 1'b1, 4'd1);
        beat("t2_c", 4'd8, 3, 1'b1, 1'b1, 4'd2);
        check_val("t2_words", 128'(words_loaded), 128'(5'd3));
        check_val("t2_busy_armed", 128'(busy), 128'(1'b1));
        check_val("t2_start_armed", 128'(start), 128'(1'b0));
        tick();
        check_val("t2_wr_idle", 128'(ctx_wr), 128'(1'b0));
        go = 1'b1;
        tick();
        go = 1'b0;
        check_val("t2_start", 128'(start), 128'(1'b1));
        check_val("t2_busy_run", 128'(busy), 128'(1'b0));
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check_val("t2_halt_start", 128'(start), 128'(1'b0));
        check_val("t2_halt_words", 128'(words_loaded), 128'(5'd0));

        // go in IDLE is ignored and not remembered.
        go = 1'b1;
        tick();
        go = 1'b0;
        check_val("idle_go_start", 128'(start), 128'(1'b0));
        check_val("idle_go_busy", 128'(busy), 128'(1'b0));

        // T3: foreign ids interleaved with our own.
        beat("t3_d",  4'd8, 4, 1'b0, 1'b1, 4'd0);
        beat("t3_x7", 4'd7, 50, 1'b1, 1'b0, 4'd0);
        beat("t3_e",  4'd8, 5, 1'b0, 1'b1, 4'd1);
        beat("t3_x9", 4'd9, 51, 1'b0, 1'b0, 4'd0);
        beat("t3_f",  4'd8, 6, 1'b1, 1'b1, 4'd2);
        check_val("t3_words", 128'(words_loaded), 128'(5'd3));
        check_val("t3_err", 128'(err_overflow), 128'(1'b0));

        // go and halt together in ARMED enters RUN.
        go   = 1'b1;
        halt = 1'b1;
        tick();
        go   = 1'b0;
        halt = 1'b0;
        check_val("gohalt_start", 128'(start), 128'(1'b1));

        // T5: beat during RUN is dropped and flagged; halt returns to IDLE.
        beat("t5_run", 4'd8, 7, 1'b0, 1'b0, 4'd0);
        check_val("t5_err", 128'(err_overflow), 128'(1'b1));
        check_val("t5_start_hold", 128'(start), 128'(1'b1));
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check_val("t5_start", 128'(start), 128'(1'b0));
        check_val("t5_busy", 128'(busy), 128'(1'b0));
        check_val("t5_words", 128'(words_loaded), 128'(5'd0));
        check_val("t5_err_sticky", 128'(err_overflow), 128'(1'b1));
        beat("t5_new", 4'd8, 8, 1'b0, 1'b1, 4'd0);
        check_val("t5_err_clr", 128'(err_overflow), 128'(1'b0));

        // T6: reset after 2 of 5 words, then reload from slot 0.
        beat("t6_w2", 4'd8, 9, 1'b0, 1'b1, 4'd1);
        RST_N = 1'b0;
        #1;
        check_val("t6_async_wr", 128'(ctx_wr), 128'(1'b0));
        check_val("t6_async_words", 128'(words_loaded), 128'(5'd0));
        check_val("t6_async_busy", 128'(busy), 128'(1'b0));
        cfg_valid = 1'b1;
        cfg_pe_id = 4'd8;
        tick();
        cfg_valid = 1'b0;
        check_val("t6_hold_wr", 128'(ctx_wr), 128'(1'b0));
        RST_N = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            beat($sformatf("t6_r%0d", i), 4'd8, 20 + i, (i == 4), 1'b1, 4'(i));
        end
        check_val("t6_words", 128'(words_loaded), 128'(5'd5));
        check_val("t6_busy", 128'(busy), 128'(1'b1));
        go = 1'b1;
        tick();
        go = 1'b0;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check_val("t6_back_idle", 128'(busy), 128'(1'b0));

        // T4: 18 beats into a 16-slot cache.
        for (int i = 0; i < 18; i++) begin
            beat($sformatf("t4_b%0d", i), 4'd8, 40 + i, (i == 17), (i < 16), 4'(i));
            if (i == 15) begin
                check_val("t4_err_full", 128'(err_overflow), 128'(1'b0));
                check_val("t4_words_full", 128'(words_loaded), 128'(5'd16));
            end
        end
        check_val("t4_err", 128'(err_overflow), 128'(1'b1));
        check_val("t4_words", 128'(words_loaded), 128'(5'd16));
        check_val("t4_busy", 128'(busy), 128'(1'b1));
        check_val("t4_start", 128'(start), 128'(1'b0));
        // halt in ARMED is ignored.
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check_val("t4_halt_busy", 128'(busy), 128'(1'b1));
        check_val("t4_halt_start", 128'(start), 128'(1'b0));
        go = 1'b1;
        tick();
        go = 1'b0;
        check_val("t4_go_start", 128'(start), 128'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
